// File: rtl/p_predict_serial.sv
// rtl/p_predict_serial.sv - serial Kalman covariance predict Pp = F*P*F^T + Q with one shared multiplier
// Uses F = [[1,DT],[0,1]] in signed Q(N-FRAC).FRAC; one product per state, then a final saturating accumulate.
module p_predict_serial #(
  parameter int N = 20,
  parameter int FRAC = 10,
  parameter logic signed [N-1:0] DT = N'(1024)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] P11,
  input  logic signed [N-1:0] P12,
  input  logic signed [N-1:0] P21,
  input  logic signed [N-1:0] P22,
  input  logic signed [N-1:0] Q11,
  input  logic signed [N-1:0] Q12,
  input  logic signed [N-1:0] Q21,
  input  logic signed [N-1:0] Q22,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] Pp11,
  output logic signed [N-1:0] Pp12,
  output logic signed [N-1:0] Pp21,
  output logic signed [N-1:0] Pp22
);

  typedef enum logic [2:0] {S_IDLE, S_M1, S_M2, S_M3, S_ACC} state_t;

  state_t state_q, state_d;
  logic signed [N-1:0] p11_q, p12_q, p21_q, p22_q;
  logic signed [N-1:0] q11_q, q12_q, q21_q, q22_q;
  logic signed [N-1:0] tp22_q, ts_q, t2_q;
  logic signed [N-1:0] pp11_q, pp12_q, pp21_q, pp22_q;
  logic                done_q;

  logic signed [N-1:0]   mul_b;
  logic signed [2*N-1:0] dt_w, b_w, prod, prod_sh;
  logic signed [N-1:0]   mul_sat, s_sat;
  logic signed [N+1:0]   sum11, sum12, sum21, sum22;

  function automatic logic signed [N-1:0] sat_prod(input logic signed [2*N-1:0] v);
    if (v > $signed({{(N+1){1'b0}}, {(N-1){1'b1}}}))
      return {1'b0, {(N-1){1'b1}}};
    else if (v < $signed({{(N+1){1'b1}}, {(N-1){1'b0}}}))
      return {1'b1, {(N-1){1'b0}}};
    else
      return v[N-1:0];
  endfunction

  function automatic logic signed [N-1:0] sat_sum(input logic signed [N+1:0] v);
    if (v > $signed({3'b000, {(N-1){1'b1}}}))
      return {1'b0, {(N-1){1'b1}}};
    else if (v < $signed({3'b111, {(N-1){1'b0}}}))
      return {1'b1, {(N-1){1'b0}}};
    else
      return v[N-1:0];
  endfunction

  function automatic logic signed [N+1:0] ext(input logic signed [N-1:0] v);
    return {{2{v[N-1]}}, v};
  endfunction

  // Only the second operand changes per state; DT is always the first.
  always_comb begin
    state_d = state_q;
    mul_b   = '0;
    case (state_q)
      S_IDLE: if (start) state_d = S_M1;
      S_M1: begin
        mul_b   = p22_q;
        state_d = S_M2;
      end
      S_M2: begin
        mul_b   = s_sat;
        state_d = S_M3;
      end
      S_M3: begin
        mul_b   = tp22_q;
        state_d = S_ACC;
      end
      S_ACC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign dt_w    = (2*N)'(DT);
  assign b_w     = (2*N)'(mul_b);
  assign prod    = dt_w * b_w;
  assign prod_sh = prod >>> FRAC;
  assign mul_sat = sat_prod(prod_sh);
  assign s_sat   = sat_sum(ext(p12_q) + ext(p21_q));

  assign sum11 = ext(p11_q) + ext(ts_q) + ext(t2_q) + ext(q11_q);
  assign sum12 = ext(p12_q) + ext(tp22_q) + ext(q12_q);
  assign sum21 = ext(p21_q) + ext(tp22_q) + ext(q21_q);
  assign sum22 = ext(p22_q) + ext(q22_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      p11_q <= '0; p12_q <= '0; p21_q <= '0; p22_q <= '0;
      q11_q <= '0; q12_q <= '0; q21_q <= '0; q22_q <= '0;
      tp22_q <= '0; ts_q <= '0; t2_q <= '0;
      pp11_q <= '0; pp12_q <= '0; pp21_q <= '0; pp22_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_ACC);
      case (state_q)
        S_IDLE: if (start) begin
          p11_q <= P11; p12_q <= P12; p21_q <= P21; p22_q <= P22;
          q11_q <= Q11; q12_q <= Q12; q21_q <= Q21; q22_q <= Q22;
        end
        S_M1: tp22_q <= mul_sat;
        S_M2: ts_q   <= mul_sat;
        S_M3: t2_q   <= mul_sat;
        S_ACC: begin
          pp11_q <= sat_sum(sum11);
          pp12_q <= sat_sum(sum12);
          pp21_q <= sat_sum(sum21);
          pp22_q <= sat_sum(sum22);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign Pp11 = pp11_q;
  assign Pp12 = pp12_q;
  assign Pp21 = pp21_q;
  assign Pp22 = pp22_q;

endmodule

// File: tb/tb_p_predict_serial.sv
// tb/tb_p_predict_serial.sv - scoreboard bench for p_predict_serial at DT=1.0 and DT=0.5
module tb_p_predict_serial;
  localparam int N = 20;
  localparam int FRAC = 10;
  localparam longint MAXV = (64'sd1 <<< (N-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (N-1));

  typedef struct {int pp11; int pp12; int pp21; int pp22;} res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic signed [N-1:0] p11 = '0, p12 = '0, p21 = '0, p22 = '0;
  logic signed [N-1:0] q11 = '0, q12 = '0, q21 = '0, q22 = '0;
  logic busy_a, done_a, busy_b, done_b;
  logic signed [N-1:0] pa11, pa12, pa21, pa22, pb11, pb12, pb21, pb22;

  res_t qa[$], qb[$];
  int n_checks = 0, n_pass = 0;
  int done_cnt_a = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  p_predict_serial #(.N(N), .FRAC(FRAC), .DT(20'sd1024)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .P11(p11), .P12(p12), .P21(p21), .P22(p22),
    .Q11(q11), .Q12(q12), .Q21(q21), .Q22(q22),
    .busy(busy_a), .done(done_a),
    .Pp11(pa11), .Pp12(pa12), .Pp21(pa21), .Pp22(pa22));

  p_predict_serial #(.N(N), .FRAC(FRAC), .DT(20'sd512)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .P11(p11), .P12(p12), .P21(p21), .P22(p22),
    .Q11(q11), .Q12(q12), .Q21(q21), .Q22(q22),
    .busy(busy_b), .done(done_b),
    .Pp11(pb11), .Pp12(pb12), .Pp21(pb21), .Pp22(pb22));

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint sat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic longint mulm(input longint dt, input longint x);
    return sat((dt * x) >>> FRAC);
  endfunction

  function automatic res_t model(input longint dt, input int a11, a12, a21, a22, b11, b12, b21, b22);
    res_t r;
    longint tp22, ts, t2;
    tp22 = mulm(dt, a22);
    ts   = mulm(dt, sat(longint'(a12) + a21));
    t2   = mulm(dt, tp22);
    r.pp11 = int'(sat(longint'(a11) + ts + t2 + b11));
    r.pp12 = int'(sat(longint'(a12) + tp22 + b12));
    r.pp21 = int'(sat(longint'(a21) + tp22 + b21));
    r.pp22 = int'(sat(longint'(a22) + b22));
    return r;
  endfunction

  always @(negedge clk) begin
    if (done_a) begin
      done_cnt_a++;
      if (qa.size() == 0) chk("a_spurious_done", 1, 0);
      else begin
        res_t e;
        e = qa.pop_front();
        chk("a_pp11", int'(pa11), e.pp11);
        chk("a_pp12", int'(pa12), e.pp12);
        chk("a_pp21", int'(pa21), e.pp21);
        chk("a_pp22", int'(pa22), e.pp22);
      end
    end
    if (done_b) begin
      if (qb.size() == 0) chk("b_spurious_done", 1, 0);
      else begin
        res_t e;
        e = qb.pop_front();
        chk("b_pp11", int'(pb11), e.pp11);
        chk("b_pp12", int'(pb12), e.pp12);
        chk("b_pp21", int'(pb21), e.pp21);
        chk("b_pp22", int'(pb22), e.pp22);
      end
    end
  end

  task automatic set_in(input int a11, a12, a21, a22, b11, b12, b21, b22);
    p11 = a11[N-1:0]; p12 = a12[N-1:0]; p21 = a21[N-1:0]; p22 = a22[N-1:0];
    q11 = b11[N-1:0]; q12 = b12[N-1:0]; q21 = b21[N-1:0]; q22 = b22[N-1:0];
  endtask

  // Called at a negedge; the request is accepted at the following posedge.
  task automatic issue(input bit sel, input int a11, a12, a21, a22, b11, b12, b21, b22);
    set_in(a11, a12, a21, a22, b11, b12, b21, b22);
    if (sel) begin
      qb.push_back(model(512, a11, a12, a21, a22, b11, b12, b21, b22));
      start_b = 1'b1;
    end else begin
      qa.push_back(model(1024, a11, a12, a21, a22, b11, b12, b21, b22));
      start_a = 1'b1;
    end
  endtask

  task automatic wait_done(input bit sel, input string tag);
    int k, busy_n;
    k = 0; busy_n = 0;
    do begin
      @(negedge clk);
      k++;
      start_a = 1'b0; start_b = 1'b0;
      if (sel ? busy_b : busy_a) busy_n++;
    end while (!(sel ? done_b : done_a) && k < 20);
    chk({tag, "_latency"}, k, 5);
    chk({tag, "_busy_cycles"}, busy_n, 4);
  endtask

  function automatic int rnd(input bit big);
    if (big) return int'($urandom_range(0, (1 << N) - 1)) - (1 << (N-1));
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  initial begin
    int t1, t2, cnt0;
    res_t e;
    @(negedge clk);
    #1;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_pp11", int'(pa11), 0);
    chk("rst_pp22", int'(pa22), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // V1 with a hand-computed expectation
    set_in(1024, 0, 0, 1024, 0, 0, 0, 0);
    e.pp11 = 2048; e.pp12 = 1024; e.pp21 = 1024; e.pp22 = 1024;
    qa.push_back(e); start_a = 1'b1;
    wait_done(1'b0, "v1");

    // V2 on the DT=0.5 instance
    @(negedge clk);
    set_in(0, -1024, -1024, 2048, 0, 0, 0, 0);
    e.pp11 = -512; e.pp12 = 0; e.pp21 = 0; e.pp22 = 2048;
    qb.push_back(e); start_b = 1'b1;
    wait_done(1'b1, "v2");

    // V3 saturation high and low
    @(negedge clk);
    set_in(524287, 0, 0, 0, 1024, 0, 0, 0);
    e.pp11 = 524287; e.pp12 = 0; e.pp21 = 0; e.pp22 = 0;
    qa.push_back(e); start_a = 1'b1;
    wait_done(1'b0, "v3hi");
    @(negedge clk);
    set_in(-524288, 0, 0, 0, -1, 0, 0, 0);
    e.pp11 = -524288;
    qa.push_back(e); start_a = 1'b1;
    wait_done(1'b0, "v3lo");

    // V4: starts in S_M1 and S_M3 with different inputs are ignored
    @(negedge clk);
    cnt0 = done_cnt_a;
    issue(1'b0, 300, -200, 150, 900, 5, 6, 7, 8);
    @(negedge clk);
    set_in(1, 2, 3, 4, 5, 6, 7, 8); start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; set_in(-9, -9, -9, -9, -9, -9, -9, -9);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (8) @(negedge clk);
    chk("v4_done_count", done_cnt_a - cnt0, 1);

    // V5: second start during the done cycle
    issue(1'b0, 100, 200, 300, 400, 1, 2, 3, 4);
    wait_done(1'b0, "v5a");
    t1 = cyc;
    issue(1'b0, -700, 50, 60, -3000, 10, 20, 30, 40);
    wait_done(1'b0, "v5b");
    t2 = cyc;
    chk("v5_done_spacing", t2 - t1, 5);

    // V6: reset during S_M2 aborts the request
    @(negedge clk);
    issue(1'b0, 4000, 1000, 1000, 4000, 0, 0, 0, 0);
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    void'(qa.pop_back());
    #1;
    chk("v6_busy", int'(busy_a), 0);
    chk("v6_done", int'(done_a), 0);
    chk("v6_pp11", int'(pa11), 0);
    chk("v6_pp12", int'(pa12), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt0 = done_cnt_a;
    repeat (8) @(negedge clk);
    chk("v6_no_done", done_cnt_a - cnt0, 0);
    chk("v6_pp22_hold0", int'(pa22), 0);
    issue(1'b0, 512, 256, -256, 2048, 3, 3, 3, 3);
    wait_done(1'b0, "v6_next");

    // Randomised requests on both instances, mixing small and full-range values
    for (int i = 0; i < 8; i++) begin
      bit big;
      int v[8];
      big = (i % 2 == 1);
      for (int j = 0; j < 8; j++) v[j] = rnd(big);
      @(negedge clk);
      issue(i[0], v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]);
      wait_done(i[0], "rand");
    end

    repeat (3) @(negedge clk);
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
